// File: rtl/pe_result_drain.sv
// Row-buffered drain for the PE result interface: captures whole output rows
// on sum_enable and serializes them word by word onto a valid/ready stream.
module pe_result_drain #(
  parameter  int WORDWIDTH = 32,
  parameter  int NUM1      = 14,
  parameter  int NUM2      = 5,
  parameter  int DEPTH     = 4,
  localparam int NOUT      = NUM1 + 1 - NUM2,
  localparam int IW        = $clog2(NOUT),
  localparam int PW        = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORDWIDTH*NOUT-1:0] result,
  input  logic                      sum_enable,
  output logic [WORDWIDTH-1:0]      m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic [IW-1:0]             m_index,
  output logic [PW:0]               level,
  output logic                      overflow,
  output logic                      busy
);

  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NOUT - 1);

  typedef enum logic {EMPTY, STREAM} state_t;

  state_t                    state_reg, state_next;
  logic [PW-1:0]             wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]               count_reg, count_next;
  logic [IW-1:0]             idx_reg;
  logic                      overflow_reg;
  logic [WORDWIDTH*NOUT-1:0] row_mem [DEPTH];
  logic [WORDWIDTH-1:0]      head_words [NOUT];
  logic                      push, drop, beat, retire;

  // Fullness uses the pre-edge count so the push path never depends on m_ready.
  assign push   = sum_enable && (count_reg != CNT_FULL);
  assign drop   = sum_enable && (count_reg == CNT_FULL);
  assign beat   = (state_reg == STREAM) && m_ready;
  assign retire = beat && (idx_reg == LAST_IDX);

  generate
    for (genvar gi = 0; gi < NOUT; gi++) begin : g_head_words
      assign head_words[gi] = row_mem[rd_ptr_reg][gi*WORDWIDTH +: WORDWIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      row_mem[wr_ptr_reg] <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      idx_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (retire) begin
        idx_reg    <= '0;
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end else if (beat) begin
        idx_reg <= idx_reg + IDX_ONE;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !retire) begin
      count_next = count_reg + CNT_ONE;
    end else if (!push && retire) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  always_comb begin
    state_next = state_reg;
    m_valid    = 1'b0;
    m_data     = '0;
    m_last     = 1'b0;
    m_index    = '0;
    case (state_reg)
      EMPTY: begin
        if (push) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        m_valid = 1'b1;
        m_data  = head_words[idx_reg];
        m_index = idx_reg;
        m_last  = (idx_reg == LAST_IDX);
        if (retire && !push && count_reg == CNT_ONE) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  assign level    = count_reg;
  assign overflow = overflow_reg;
  assign busy     = (count_reg != '0) || sum_enable;

endmodule

// File: tb/tb_pe_result_drain.sv
// Randomized self-checking bench for pe_result_drain against a row-queue model.
module tb_pe_result_drain;

  localparam int W     = 32;
  localparam int NUM1  = 14;
  localparam int NUM2  = 5;
  localparam int DEPTH = 4;
  localparam int NOUT  = NUM1 + 1 - NUM2;
  localparam int IW    = $clog2(NOUT);
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int ROWW  = W * NOUT;
  localparam int VW    = 4 + IW + LW + W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ROWW-1:0] result = '0;
  logic            sum_enable = 1'b0;
  logic            m_ready = 1'b0;
  logic [W-1:0]    m_data;
  logic            m_valid;
  logic            m_last;
  logic [IW-1:0]   m_index;
  logic [LW-1:0]   level;
  logic            overflow;
  logic            busy;

  always #5 clk = ~clk;

  pe_result_drain #(.WORDWIDTH(W), .NUM1(NUM1), .NUM2(NUM2), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .result(result), .sum_enable(sum_enable),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_index(m_index), .level(level), .overflow(overflow), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of whole rows, position of next word in the head row.
  logic [ROWW-1:0] mq[$];
  int              pos = 0;
  bit              movf = 1'b0;
  logic [W+IW:0]   beats[$];

  wire [VW-1:0] dut_vec = {m_valid, m_last, m_index, level, overflow, busy, m_data};

  function automatic logic [VW-1:0] model_vec();
    logic          v;
    logic [W-1:0]  d;
    logic          lst;
    logic [IW-1:0] ix;
    logic [LW-1:0] lv;
    logic          bz;
    v   = (mq.size() != 0);
    d   = v ? mq[0][pos*W +: W] : '0;
    lst = v && (pos == NOUT - 1);
    ix  = v ? IW'(pos) : '0;
    lv  = LW'(mq.size());
    bz  = (mq.size() != 0) || sum_enable;
    return {v, lst, ix, lv, movf, bz, d};
  endfunction

  function automatic logic [ROWW-1:0] seq_row(input logic [W-1:0] base);
    logic [ROWW-1:0] r;
    for (int i = 0; i < NOUT; i++) r[i*W +: W] = base + W'(i);
    return r;
  endfunction

  function automatic logic [ROWW-1:0] rnd_row(input logic [W-1:0] base);
    logic [ROWW-1:0] r;
    r[0 +: W] = base;
    for (int i = 1; i < NOUT; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  task automatic tick(input bit se, input logic [ROWW-1:0] row, input bit rdy);
    bit full, bt;
    sum_enable = se;
    result     = row;
    m_ready    = rdy;
    if (m_valid && rdy) beats.push_back({m_last, m_index, m_data});
    @(posedge clk);
    full = (mq.size() == DEPTH);
    bt   = (mq.size() != 0) && rdy;
    if (bt) begin
      pos++;
      if (pos == NOUT) begin
        void'(mq.pop_front());
        pos = 0;
      end
    end
    if (se) begin
      if (full) movf = 1'b1;
      else mq.push_back(row);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sum_enable = 1'b0; m_ready = 1'b0; result = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete(); pos = 0; movf = 1'b0; beats.delete();
  endtask

  task automatic test_reset();
    do_reset();
    if (dut_vec !== model_vec()) begin
      errors++; $display("FAIL reset_state: got %h exp %h", dut_vec, model_vec());
    end
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || level !== '0) begin
      errors++; $display("FAIL reset_outputs: got valid=%b data=%h level=%0d exp 0/0/0", m_valid, m_data, level);
    end
    checks++;
  endtask

  task automatic test_single_row();
    logic [W+IW:0] exp_b;
    do_reset();
    tick(1'b1, seq_row(32'h3F80_0000), 1'b1);
    if (m_valid !== 1'b1) begin
      errors++; $display("FAIL single_latency: got valid=%b exp 1", m_valid);
    end
    checks++;
    for (int k = 0; k < NOUT; k++) begin
      tick(1'b0, '0, 1'b1);
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL single_cycle%0d: got %h exp %h", k, dut_vec, model_vec());
      end
      checks++;
    end
    if (beats.size() != NOUT) begin
      errors++; $display("FAIL single_beats: got %0d exp %0d", beats.size(), NOUT);
    end else begin
      for (int i = 0; i < NOUT; i++) begin
        exp_b = {(i == NOUT - 1), IW'(i), 32'h3F80_0000 + W'(i)};
        if (beats[i] !== exp_b) begin
          errors++; $display("FAIL single_word%0d: got %h exp %h", i, beats[i], exp_b);
        end
        checks++;
      end
    end
    checks++;
    if (m_valid !== 1'b0 || level !== '0) begin
      errors++; $display("FAIL single_drained: got valid=%b level=%0d exp 0/0", m_valid, level);
    end
    checks++;
  endtask

  task automatic test_backpressure();
    bit            rdy, stall;
    logic [W-1:0]  pd;
    logic [IW-1:0] pix;
    do_reset();
    tick(1'b1, seq_row(32'h3F80_0000), 1'b1);
    for (int k = 0; k < 60 && mq.size() != 0; k++) begin
      rdy   = (k % 4 == 0) || (k % 4 == 3);
      stall = m_valid && !rdy;
      pd    = m_data;
      pix   = m_index;
      tick(1'b0, '0, rdy);
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL bp_cycle%0d: got %h exp %h", k, dut_vec, model_vec());
      end
      checks++;
      if (stall && (m_valid !== 1'b1 || m_data !== pd || m_index !== pix)) begin
        errors++; $display("FAIL bp_stall%0d: got %h/%0d exp %h/%0d", k, m_data, m_index, pd, pix);
      end
      if (stall) checks++;
    end
    if (mq.size() != 0 || beats.size() != NOUT) begin
      errors++; $display("FAIL bp_beats: got %0d exp %0d", beats.size(), NOUT);
    end else begin
      for (int i = 0; i < NOUT; i++) begin
        if (beats[i][W+IW-1:0] !== {IW'(i), 32'h3F80_0000 + W'(i)}) begin
          errors++; $display("FAIL bp_word%0d: got %h exp %h", i, beats[i][W-1:0], 32'h3F80_0000 + W'(i));
        end
        checks++;
      end
    end
    checks++;
  endtask

  task automatic test_fill();
    logic [W-1:0] base;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      base = 32'hA000_0000 + W'(j) * 32'h1000_0000;
      tick(1'b1, rnd_row(base), 1'b0);
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL fill_push%0d: got %h exp %h", j, dut_vec, model_vec());
      end
      checks++;
      if (j == 3 && (level !== LW'(4) || overflow !== 1'b0)) begin
        errors++; $display("FAIL fill_full: got level=%0d ovf=%b exp 4/0", level, overflow);
      end
      if (j == 4 && (level !== LW'(4) || overflow !== 1'b1)) begin
        errors++; $display("FAIL fill_drop: got level=%0d ovf=%b exp 4/1", level, overflow);
      end
      if (j >= 3) checks++;
    end
    for (int k = 0; k < 4 * NOUT; k++) begin
      tick(1'b0, '0, 1'b1);
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL fill_drain%0d: got %h exp %h", k, dut_vec, model_vec());
      end
      checks++;
    end
    if (beats.size() != 4 * NOUT) begin
      errors++; $display("FAIL fill_beats: got %0d exp %0d", beats.size(), 4 * NOUT);
    end else begin
      for (int j = 0; j < 4; j++) begin
        base = 32'hA000_0000 + W'(j) * 32'h1000_0000;
        if (beats[j*NOUT][W-1:0] !== base) begin
          errors++; $display("FAIL fill_row%0d: got %h exp %h", j, beats[j*NOUT][W-1:0], base);
        end
        checks++;
      end
      for (int i = 0; i < beats.size(); i++) begin
        if (beats[i][W-1:0] === 32'hE000_0000) begin
          errors++; $display("FAIL fill_e_seen: got %h at beat %0d exp absent", beats[i][W-1:0], i);
        end
      end
      checks++;
    end
    checks++;
    if (overflow !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL fill_end: got ovf=%b valid=%b exp 1/0", overflow, m_valid);
    end
    checks++;
  endtask

  task automatic test_simultaneous();
    logic [ROWW-1:0] f;
    int              n;
    // Part 1: two rows queued, new row lands on the head row's final beat.
    do_reset();
    f = rnd_row(32'hF000_0000);
    tick(1'b1, rnd_row(32'h1111_0000), 1'b0);
    tick(1'b1, rnd_row(32'h2222_0000), 1'b0);
    for (int k = 0; k < NOUT - 1; k++) tick(1'b0, '0, 1'b1);
    tick(1'b1, f, 1'b1);
    if (level !== LW'(2) || dut_vec !== model_vec()) begin
      errors++; $display("FAIL simul_level2: got level=%0d vec=%h exp 2 vec=%h", level, dut_vec, model_vec());
    end
    checks++;
    for (int k = 0; k < 3 * NOUT && mq.size() != 0; k++) begin
      tick(1'b0, '0, 1'b1);
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL simul_drain%0d: got %h exp %h", k, dut_vec, model_vec());
      end
      checks++;
    end
    n = beats.size();
    if (n != 3 * NOUT) begin
      errors++; $display("FAIL simul_beats: got %0d exp %0d", n, 3 * NOUT);
    end else begin
      for (int i = 0; i < NOUT; i++) begin
        if (beats[n-NOUT+i][W-1:0] !== f[i*W +: W]) begin
          errors++; $display("FAIL simul_f_word%0d: got %h exp %h", i, beats[n-NOUT+i][W-1:0], f[i*W +: W]);
        end
        checks++;
      end
    end
    checks++;
    // Part 2: same timing with a full buffer drops the row.
    do_reset();
    for (int j = 0; j < DEPTH; j++) tick(1'b1, rnd_row(32'h3000_0000 + W'(j)), 1'b0);
    for (int k = 0; k < NOUT - 1; k++) tick(1'b0, '0, 1'b1);
    tick(1'b1, f, 1'b1);
    if (level !== LW'(DEPTH - 1) || overflow !== 1'b1) begin
      errors++; $display("FAIL simul_full_drop: got level=%0d ovf=%b exp %0d/1", level, overflow, DEPTH - 1);
    end
    checks++;
    for (int k = 0; k < DEPTH * NOUT && mq.size() != 0; k++) begin
      tick(1'b0, '0, 1'b1);
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL simul_full_drain%0d: got %h exp %h", k, dut_vec, model_vec());
      end
      checks++;
    end
  endtask

  task automatic test_wrap_random();
    logic [W-1:0]    exp_words[$];
    logic [ROWW-1:0] row;
    bit              se, rdy;
    int              pushed, cyc;
    do_reset();
    pushed = 0;
    cyc    = 0;
    while ((pushed < 9 || mq.size() != 0) && cyc < 3000) begin
      se  = (pushed < 9) && (mq.size() < DEPTH) && ($urandom_range(0, 2) != 0);
      row = rnd_row($urandom);
      rdy = $urandom_range(0, 1) != 0;
      if (se) begin
        pushed++;
        for (int i = 0; i < NOUT; i++) exp_words.push_back(row[i*W +: W]);
      end
      tick(se, row, rdy);
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL wrap_cycle%0d: got %h exp %h", cyc, dut_vec, model_vec());
      end
      checks++;
      cyc++;
    end
    if (cyc >= 3000) begin
      errors++; $display("FAIL wrap_timeout: got %0d rows pushed, %0d queued exp drained", pushed, mq.size());
    end
    checks++;
    if (beats.size() != exp_words.size() || beats.size() != 9 * NOUT) begin
      errors++; $display("FAIL wrap_beats: got %0d exp %0d", beats.size(), 9 * NOUT);
    end else begin
      for (int i = 0; i < beats.size(); i++) begin
        if (beats[i][W-1:0] !== exp_words[i] || beats[i][W+IW-1:W] !== IW'(i % NOUT)) begin
          errors++; $display("FAIL wrap_word%0d: got %h idx %0d exp %h idx %0d", i, beats[i][W-1:0], beats[i][W+IW-1:W], exp_words[i], i % NOUT);
        end
        checks++;
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL wrap_overflow: got %b exp 0", overflow);
    end
    checks++;
  endtask

  task automatic test_reset_midstream();
    logic [ROWW-1:0] g;
    do_reset();
    tick(1'b1, rnd_row(32'h5000_0000), 1'b0);
    tick(1'b1, rnd_row(32'h5100_0000), 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b0, '0, 1'b1);
    rst = 1'b1; sum_enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete(); pos = 0; movf = 1'b0; beats.delete();
    if (m_valid !== 1'b0 || level !== '0 || m_data !== '0 || overflow !== 1'b0) begin
      errors++; $display("FAIL midrst_state: got valid=%b level=%0d data=%h ovf=%b exp 0/0/0/0", m_valid, level, m_data, overflow);
    end
    checks++;
    g = rnd_row(32'h6000_0000);
    tick(1'b1, g, 1'b1);
    for (int k = 0; k < NOUT; k++) begin
      tick(1'b0, '0, 1'b1);
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL midrst_cycle%0d: got %h exp %h", k, dut_vec, model_vec());
      end
      checks++;
    end
    if (beats.size() != NOUT || beats[0] !== {1'b0, IW'(0), g[0 +: W]}) begin
      errors++; $display("FAIL midrst_first: got %0d beats first %h exp %0d beats first %h", beats.size(), beats.size() != 0 ? beats[0] : '0, NOUT, {1'b0, IW'(0), g[0 +: W]});
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_backpressure();
    test_fill();
    test_simultaneous();
    test_wrap_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_result_drain.md
Name: pe_result_drain

Overview:
- Receiving end of the PE result interface. Captures each completed output row, i.e. the `result` vector qualified by `sum_enable`.
- Buffers up to DEPTH rows and serializes them one word per beat onto a valid/ready stream toward the output buffer/DMA.
- Reports overflow when the PE produces rows faster than downstream drains them.

Parameters:
- WORDWIDTH, 32, bits per result word (FP32)
- NUM1, 14, activation row length of the PE
- NUM2, 5, kernel length of the PE
- DEPTH, 4, row-buffer entries; power of two, >=2
- NOUT is derived, not a parameter: NOUT = NUM1+1-NUM2 (10 words per row)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- result  in  WORDWIDTH*NOUT  PE row output; word i = bits [i*WORDWIDTH +: WORDWIDTH]
- sum_enable  in  1  row-valid strobe from PE; each high cycle is one row
- m_data  out  WORDWIDTH  stream word
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts the beat
- m_last  out  1  high on the final word (index NOUT-1) of a row
- m_index  out  $clog2(NOUT)  word index within the current row
- level  out  $clog2(DEPTH)+1  rows held, including a partially drained row
- overflow  out  1  sticky; a row was dropped
- busy  out  1  level!=0 or sum_enable

Behaviour:
Reset and state
- Reset (rst high at a posedge): wr_ptr, rd_ptr, count, idx = 0; overflow = 0. Buffer contents are don't-care.
- Reset outputs: m_valid=0, m_data=0, m_last=0, m_index=0, level=0.
- Reset mid-stream discards all rows, including a partially sent one. The next beat after reset is word 0 of the next captured row.
- Two states:
  - EMPTY (count==0): m_valid=0, m_data=0.
  - STREAM (count>0): m_valid=1, m_data = buf[rd_ptr] word idx, m_index=idx, m_last=(idx==NOUT-1).

Capture
- At a posedge with sum_enable=1 and count<DEPTH: buf[wr_ptr] <= result; wr_ptr increments, wrapping modulo DEPTH.
- A row captured at edge N makes m_valid high in the cycle after edge N. Latency is 1 cycle; there is no combinational path from result to m_data.
- sum_enable high with count==DEPTH: the row is dropped and overflow <= 1.
  - The full check uses count before the edge. A row arriving while the last word of a full buffer pops is still dropped. This is deliberate and keeps the push path independent of m_ready.
- overflow clears only on rst.

Drain
- A beat transfers when m_valid && m_ready at a posedge; idx increments.
- On the beat with idx==NOUT-1: idx <= 0, rd_ptr increments (wrap), and the row retires.
- While m_valid && !m_ready: m_data, m_index and m_last hold stable. m_valid never drops until the row completes.
- Words go out in index order 0..NOUT-1; rows go out in capture order.

Count
- Push only: count+1. Row retire only: count-1. Push and retire in the same edge: count unchanged.
- level = count.
- EMPTY -> STREAM on a push. STREAM -> EMPTY on a retire with no push and count==1.

Arithmetic
- Pointers are $clog2(DEPTH) bits, wrapping naturally.
- count is one bit wider than the pointers.
- No data arithmetic; words pass through bit-exact. NaN and denormal patterns are untouched.

Test Plan:
- Single row, m_ready=1, result words 0x3F800000+i (i=0..9), one-cycle sum_enable -> m_valid rises the next cycle. Ten consecutive beats carry 0x3F800000..0x3F800009 with m_index 0..9; m_last only on the 10th beat; level returns 0 and m_valid falls after the 10th beat.
- Backpressure: same row, m_ready toggled 1,0,0,1,... -> no word skipped or repeated, m_data stable during every stall, 10 beats total, order preserved.
- Fill: m_ready=0, four rows A,B,C,D (word0 = 0xA0000000.. 0xD0000000) on consecutive cycles -> level=4, overflow=0. Fifth row E -> dropped, overflow=1, level stays 4. Release m_ready -> 40 beats A..D, E never appears, overflow still 1.
- Simultaneous push and retire: level=2, push row F on the same edge as the last beat of the head row -> level stays 2, F emitted after the remaining row. Repeat at level=4 -> F dropped, overflow set.
- Wrap-around: stream 9 rows through DEPTH=4 with random m_ready (~50%) and random sum_enable gaps, never exceeding capacity -> all 90 words match a scoreboard in order, overflow=0.
- Reset mid-stream: assert rst after beat 3 of a row with 2 rows queued -> next cycle m_valid=0, level=0, m_data=0, overflow=0. A new row G after reset emits from word 0.
